approx_mul_err_sweeper: RTL

//  Exhaustive error-characterisation sequencer for one combinational approximate WxW unsigned multiplier.

---
 rtl/approx_mul_pkg.sv | 24 ++
 rtl/approx_mul_err_sweeper_if.sv | 11 +
 rtl/approx_err_accum.sv | 90 +++++++++
 rtl/approx_mul_err_sweeper.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// rtl/approx_mul_pkg.sv - shared types and constants for the approximate-multiplier error sweeper
package approx_mul_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_SSE_W = 48;
    localparam int DEF_SUM_W = 34;
    localparam int DRAIN_CYC = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sweep_state_e;

    // err holds the two's-complement difference approx - exact, one bit wider than the product
    typedef struct packed {
        logic [2*DEF_W:0]   err;
        logic [DEF_W-1:0]   a;
        logic [DEF_W-1:0]   b;
        logic               valid;
    } err_rec_t;

endpackage

// File: rtl/approx_mul_err_sweeper_if.sv
// rtl/approx_mul_err_sweeper_if.sv - operand/product bus between the sweeper and the multiplier under test
interface approx_mul_err_sweeper_if #(
    parameter int W = 8
);
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2*W-1:0] approx_p;

    modport master (output op_a, output op_b, input approx_p);
    modport slave  (input op_a, input op_b, output approx_p);
endinterface

// File: rtl/approx_err_accum.sv
// rtl/approx_err_accum.sv - error accumulator and first-maximum tracker
module approx_err_accum
    import approx_mul_pkg::*;
#(
    parameter int  W     = DEF_W,
    parameter int  SSE_W = DEF_SSE_W,
    parameter int  SUM_W = DEF_SUM_W,
    parameter type rec_t = err_rec_t
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  rec_t             rec,
    output logic [SSE_W-1:0] sse,
    output logic [SUM_W-1:0] err_sum,
    output logic [2*W-1:0]   max_abs,
    output logic [W-1:0]     max_a,
    output logic [W-1:0]     max_b,
    output logic [2*W:0]     err_cnt
);

    logic [SSE_W-1:0] sse_q, sse_d;
    logic [SUM_W-1:0] err_sum_q, err_sum_d;
    logic [2*W-1:0]   max_abs_q, max_abs_d;
    logic [W-1:0]     max_a_q, max_a_d;
    logic [W-1:0]     max_b_q, max_b_d;
    logic [2*W:0]     err_cnt_q, err_cnt_d;

    logic signed [2*W:0] err_s;
    logic [2*W-1:0]      abs_err;
    logic [4*W-1:0]      sq_err;

    // |err| always fits 2W bits: the approximate product is at most 2^(2W)-1
    assign err_s   = $signed(rec.err);
    assign abs_err = err_s[2*W] ? (2*W)'(-err_s) : (2*W)'(err_s);
    assign sq_err  = (4*W)'(abs_err) * (4*W)'(abs_err);

    always_comb begin
        sse_d     = sse_q;
        err_sum_d = err_sum_q;
        max_abs_d = max_abs_q;
        max_a_d   = max_a_q;
        max_b_d   = max_b_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            sse_d     = '0;
            err_sum_d = '0;
            max_abs_d = '0;
            max_a_d   = '0;
            max_b_d   = '0;
            err_cnt_d = '0;
        end else if (rec.valid) begin
            sse_d     = sse_q + SSE_W'(sq_err);
            err_sum_d = err_sum_q + SUM_W'(err_s);
            err_cnt_d = err_cnt_q + {{(2*W){1'b0}}, (err_s != '0)};
            // strict compare keeps the earliest pair in sweep order on ties
            if (abs_err > max_abs_q) begin
                max_abs_d = abs_err;
                max_a_d   = rec.a;
                max_b_d   = rec.b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sse_q     <= '0;
            err_sum_q <= '0;
            max_abs_q <= '0;
            max_a_q   <= '0;
            max_b_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            sse_q     <= sse_d;
            err_sum_q <= err_sum_d;
            max_abs_q <= max_abs_d;
            max_a_q   <= max_a_d;
            max_b_q   <= max_b_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sse     = sse_q;
    assign err_sum = err_sum_q;
    assign max_abs = max_abs_q;
    assign max_a   = max_a_q;
    assign max_b   = max_b_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: rtl/approx_mul_err_sweeper.sv
// rtl/approx_mul_err_sweeper.sv - exhaustive error-characterisation sequencer for an approximate multiplier
module approx_mul_err_sweeper
    import approx_mul_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int SSE_W = DEF_SSE_W,
    parameter int SUM_W = DEF_SUM_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    approx_mul_err_sweeper_if.master  mul,
    output logic                      busy,
    output logic                      done,
    output logic                      res_valid,
    output logic [SSE_W-1:0]          sse,
    output logic [SUM_W-1:0]          err_sum,
    output logic [2*W-1:0]            max_abs,
    output logic [W-1:0]              max_a,
    output logic [W-1:0]              max_b,
    output logic [2*W:0]              err_cnt
);

    localparam int DRW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRW-1:0] DRAIN_LAST = DRW'(DRAIN_CYC - 1);

    typedef struct packed {
        logic [2*W:0] err;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         valid;
    } rec_t;

    sweep_state_e   state_q, state_d;
    logic [2*W-1:0] cnt_q, cnt_d;
    logic [DRW-1:0] drain_q, drain_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           res_valid_q, res_valid_d;
    rec_t           s1_q, s1_d;

    logic           clr;
    logic [2*W-1:0] cnt_inc;
    logic [2*W-1:0] exact_p;
    rec_t           acc_rec;

    assign cnt_inc = cnt_q + (2*W)'(1);
    assign exact_p = (2*W)'(op_a_q) * (2*W)'(op_b_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        res_valid_d = res_valid_q;
        clr         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (abort) begin
                    res_valid_d = 1'b0;
                end else if (start) begin
                    state_d     = ST_RUN;
                    clr         = 1'b1;
                    res_valid_d = 1'b0;
                    cnt_d       = '0;
                    op_a_d      = '0;
                    op_b_d      = '0;
                    busy_d      = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    // operands freeze on the last pair; the counter itself wraps
                    if (cnt_q == '1) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        {op_a_d, op_b_d} = cnt_inc;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    drain_d = drain_q + DRW'(1);
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                done_d      = 1'b1;
                res_valid_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        s1_d.err   = {1'b0, mul.approx_p} - {1'b0, exact_p};
        s1_d.a     = op_a_q;
        s1_d.b     = op_b_q;
        s1_d.valid = (state_q == ST_RUN) && !abort;
    end

    // an abort must not let the record already in S1 reach the accumulators
    always_comb begin
        acc_rec       = s1_q;
        acc_rec.valid = s1_q.valid && !(abort && busy_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            drain_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            s1_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_valid_q <= res_valid_d;
            s1_q        <= s1_d;
        end
    end

    approx_err_accum #(
        .W     (W),
        .SSE_W (SSE_W),
        .SUM_W (SUM_W),
        .rec_t (rec_t)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .rec     (acc_rec),
        .sse     (sse),
        .err_sum (err_sum),
        .max_abs (max_abs),
        .max_a   (max_a),
        .max_b   (max_b),
        .err_cnt (err_cnt)
    );

    assign mul.op_a  = op_a_q;
    assign mul.op_b  = op_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = res_valid_q;

endmodule
